ring_counter_param: RTL and testbench

Parameterised start/stop ring/Johnson counter, successor to the fixed 16-bit ring counter in the counters-and-timers library. It adds:
- configurable width;
- runtime ring or Johnson mode and direction;
- load and single-step while idle;
- an optional auto-stop run length, with wrap and done pulses;
- ring-mode self-correction.

Outputs are tri-stated when the block is not enabled, so several counters can share a bus.

---
 rtl/ring_counter_param.sv | 114 +++++++++++
 tb/tb_ring_counter_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ring_counter_param.sv
// Start/stop ring or Johnson counter with load, single-step, auto-stop run length,
// wrap/done pulses and tri-stated outputs for bus sharing.
module ring_counter_param #(
    parameter int WIDTH         = 16,
    parameter int RUN_LEN_WIDTH = 16
) (
    input  logic                     Clk_In,
    input  logic                     tb_Reset_In,
    input  logic                     Enable_In,
    input  logic                     Start_Counter_Command_In,
    input  logic                     Stop_Counter_Command_In,
    input  logic                     Mode_In,
    input  logic                     Direction_In,
    input  logic                     Load_In,
    input  logic [WIDTH-1:0]         Load_Value_In,
    input  logic                     Step_Command_In,
    input  logic [RUN_LEN_WIDTH-1:0] Run_Length_In,
    output logic                     Counter_Running_Flag_Out,
    output logic [WIDTH-1:0]         Counter_Count_Out,
    output logic                     Wrap_Pulse_Out,
    output logic                     Done_Pulse_Out
);

    logic [WIDTH-1:0]         state_q, state_d;
    logic [RUN_LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic                     mode_q, mode_d;
    logic                     running_q, running_d;
    logic                     wrap_q, wrap_d;
    logic                     done_q, done_d;
    logic                     advance;

    function automatic logic [WIDTH-1:0] home_pattern(input logic johnson);
        return johnson ? '0 : WIDTH'(1);
    endfunction

    // Ring mode snaps any non-one-hot state back to home instead of rotating it.
    function automatic logic [WIDTH-1:0] next_pattern(input logic [WIDTH-1:0] s,
                                                      input logic johnson,
                                                      input logic dir);
        logic fb;
        if (!johnson && ($countones(s) != 1))
            return home_pattern(1'b0);
        fb = dir ? s[0] : s[WIDTH-1];
        if (johnson)
            fb = ~fb;
        return dir ? {fb, s[WIDTH-1:1]} : {s[WIDTH-2:0], fb};
    endfunction

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        running_d   = running_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        advance     = 1'b0;

        if (Start_Counter_Command_In) begin
            if (!running_q) begin
                mode_d    = Mode_In;
                running_d = 1'b1;
                if (Mode_In != mode_q)
                    state_d = home_pattern(Mode_In);
            end else begin
                advance = 1'b1;
            end
            remaining_d = Run_Length_In;
        end else if (Stop_Counter_Command_In) begin
            advance   = running_q;
            running_d = 1'b0;
        end else if (running_q) begin
            advance = 1'b1;
            if (remaining_q != '0) begin
                remaining_d = remaining_q - RUN_LEN_WIDTH'(1);
                if (remaining_q == RUN_LEN_WIDTH'(1)) begin
                    running_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
        end else if (Load_In) begin
            state_d = Load_Value_In;
        end else if (Step_Command_In) begin
            advance = 1'b1;
        end

        if (advance)
            state_d = next_pattern(state_q, mode_q, Direction_In);
        // Mode only changes on start from idle, where no advance happens, so mode_q is current here.
        wrap_d = advance && (state_d == home_pattern(mode_q));
    end

    always_ff @(posedge Clk_In or posedge tb_Reset_In) begin
        if (tb_Reset_In) begin
            state_q     <= WIDTH'(1);
            mode_q      <= 1'b0;
            running_q   <= 1'b0;
            remaining_q <= '0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            running_q   <= running_d;
            remaining_q <= remaining_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
        end
    end

    assign Counter_Count_Out        = Enable_In ? state_q   : 'z;
    assign Counter_Running_Flag_Out = Enable_In ? running_q : 1'bz;
    assign Wrap_Pulse_Out           = Enable_In ? wrap_q    : 1'bz;
    assign Done_Pulse_Out           = Enable_In ? done_q    : 1'bz;

endmodule

// File: tb/tb_ring_counter_param.sv
// Scoreboard bench: driver updates a position/arithmetic reference model and queues
// the expected outputs; a negedge monitor pops and compares every cycle.
module tb_ring_counter_param;
    localparam int W = 16;
    localparam int RL = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1, start = 1'b0, stop = 1'b0, mode = 1'b0, dir = 1'b0;
    logic          load = 1'b0, step = 1'b0;
    logic [W-1:0]  lval = '0;
    logic [RL-1:0] rlen = '0;
    wire  [W-1:0]  cnt;
    wire           run_f, wrap_f, done_f;

    ring_counter_param #(.WIDTH(W), .RUN_LEN_WIDTH(RL)) dut (
        .Clk_In(clk), .tb_Reset_In(rst), .Enable_In(en),
        .Start_Counter_Command_In(start), .Stop_Counter_Command_In(stop),
        .Mode_In(mode), .Direction_In(dir), .Load_In(load), .Load_Value_In(lval),
        .Step_Command_In(step), .Run_Length_In(rlen),
        .Counter_Running_Flag_Out(run_f), .Counter_Count_Out(cnt),
        .Wrap_Pulse_Out(wrap_f), .Done_Pulse_Out(done_f)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] cnt;
        bit run, wrap, done, en;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0, n_bad = 0;

    // Reference model state
    logic [W-1:0]  m_state;
    logic [RL-1:0] m_rem;
    bit            m_mode, m_run, m_wrap, m_done;

    function automatic logic [W-1:0] m_home(bit j);
        return j ? '0 : W'(1);
    endfunction

    // Ring: move the single set bit one position; Johnson: shift with inverted feedback.
    function automatic logic [W-1:0] m_adv(logic [W-1:0] s, bit j, bit d);
        logic [W-1:0] r;
        int p;
        if (!j) begin
            if ($countones(s) != 1) return W'(1);
            p = 0;
            for (int i = 0; i < W; i++) if (s[i]) p = i;
            p = d ? (p + W - 1) % W : (p + 1) % W;
            r = '0;
            r[p] = 1'b1;
            return r;
        end
        if (!d) begin r = s << 1; r[0] = ~s[W-1]; end
        else    begin r = s >> 1; r[W-1] = ~s[0]; end
        return r;
    endfunction

    task automatic m_reset();
        m_state = W'(1); m_mode = 0; m_run = 0; m_rem = '0; m_wrap = 0; m_done = 0;
    endtask

    task automatic m_edge();
        bit adv = 0;
        m_done = 0;
        if (start) begin
            if (!m_run) begin
                if (mode != m_mode) m_state = m_home(mode);
                m_mode = mode;
                m_run = 1;
            end else adv = 1;
            m_rem = rlen;
        end else if (stop) begin
            adv = m_run;
            m_run = 0;
        end else if (m_run) begin
            adv = 1;
            if (m_rem != 0) begin
                if (m_rem == 1) begin m_run = 0; m_done = 1; end
                m_rem = m_rem - 1;
            end
        end else if (load) m_state = lval;
        else if (step) adv = 1;
        if (adv) m_state = m_adv(m_state, m_mode, dir);
        m_wrap = adv && (m_state == m_home(m_mode));
    endtask

    function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // A disabled output must not drive its value; 2-state simulators read the released net as 0.
    function automatic void chk_off(string nm, logic [W-1:0] act);
        n_cmp++;
        if (!(act === 'z || act === '0)) begin
            n_bad++;
            $display("FAIL %s: got %h expected released (z)", nm, act);
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.cnt = m_state; e.run = m_run; e.wrap = m_wrap; e.done = m_done; e.en = en;
        q.push_back(e);
    endfunction

    // Monitor: outputs settled from the previous rising edge are compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.en) begin
                    chk("count", cnt, e.cnt);
                    chk("running", W'(run_f), W'(e.run));
                    chk("wrap", W'(wrap_f), W'(e.wrap));
                    chk("done", W'(done_f), W'(e.done));
                end else begin
                    chk_off("count_z", cnt);
                    chk_off("running_z", W'(run_f));
                end
            end
        end
    end

    task automatic cyc(bit st, bit sp, bit md, bit dr, bit ld, logic [W-1:0] lv,
                       bit stp, logic [RL-1:0] rl, bit e);
        start = st; stop = sp; mode = md; dir = dr; load = ld; lval = lv;
        step = stp; rlen = rl; en = e;
        m_edge();
        push_exp();
        @(negedge clk); #1;
    endtask

    task automatic idle(int n, bit d = 0);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, d, 0, '0, 0, '0, 1);
    endtask

    // Reset asserted between edges must take effect before any clock edge.
    task automatic do_reset();
        start = 0; stop = 0; load = 0; step = 0; en = 1;
        rst = 1;
        m_reset();
        #1;
        chk("rst_count", cnt, W'(1));
        chk("rst_running", W'(run_f), '0);
        chk("rst_done", W'(done_f), '0);
        chk("rst_wrap", W'(wrap_f), '0);
        push_exp();
        @(negedge clk); #1;
        rst = 0;
    endtask

    initial begin
        m_reset();
        @(negedge clk); #1;
        do_reset();
        idle(2);
        cyc(0, 0, 0, 0, 0, '0, 0, '0, 0);
        cyc(0, 0, 0, 0, 0, '0, 0, '0, 0);
        idle(1);
        // Ring free-run, direction toward MSB, full lap then stop
        cyc(1, 0, 0, 0, 0, '0, 0, '0, 1);
        idle(17);
        cyc(0, 1, 0, 0, 0, '0, 0, '0, 1);
        idle(2);
        // Johnson, run length 5, from ring mode
        cyc(1, 0, 1, 0, 0, '0, 0, 16'd5, 1);
        idle(7);
        // Back to ring (home loaded), one advance then idle
        cyc(1, 0, 0, 0, 0, '0, 0, 16'd1, 1);
        idle(3);
        cyc(0, 0, 0, 0, 1, 16'h0005, 0, '0, 1);
        cyc(0, 0, 0, 0, 0, '0, 1, '0, 1);
        cyc(0, 0, 0, 0, 1, 16'h8000, 0, '0, 1);
        cyc(0, 0, 0, 1, 0, '0, 1, '0, 1);
        // Load while running is ignored
        cyc(1, 0, 0, 0, 0, '0, 0, '0, 1);
        cyc(0, 0, 0, 0, 1, 16'h1234, 0, '0, 1);
        cyc(0, 1, 0, 0, 0, '0, 0, '0, 1);
        idle(1);
        // Start and stop together, then restart while running with length 3
        cyc(1, 1, 0, 0, 0, '0, 0, '0, 1);
        idle(2);
        cyc(1, 0, 0, 0, 0, '0, 0, 16'd3, 1);
        idle(5);
        // Reset in the middle of a run
        cyc(1, 0, 0, 0, 0, '0, 0, '0, 1);
        idle(3);
        do_reset();
        idle(1);
        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else cyc($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 5, 1'($urandom),
                     1'($urandom), $urandom_range(0, 99) < 15, W'($urandom),
                     $urandom_range(0, 99) < 25, RL'($urandom_range(0, 12)),
                     $urandom_range(0, 99) < 92);
        end
        idle(1);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d expected entries left unchecked, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
